// File: rtl/axi_ram_responder.sv
// AXI4 responder backed by on-chip byte-addressable RAM.
// Independent write (AW/W/B) and read (AR/R) FSMs over one shared array.
module axi_ram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int OFF = $clog2(STRB_WIDTH);
  localparam int WI  = ADDR_WIDTH - OFF;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [2**WI];

  // WRAP only for power-of-two beat counts; anything else walks like INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [7:0]            len,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    logic                  wrap_ok;
    inc     = a + ADDR_WIDTH'(STRB_WIDTH);
    mask    = ADDR_WIDTH'(((32'(len) + 32'd1) << OFF) - 32'd1);
    wrap_ok = len inside {8'd1, 8'd3, 8'd7, 8'd15};
    unique case (1'b1)
      (burst == 2'b00):
        next_addr = a;
      (burst == 2'b10) && wrap_ok:
        next_addr = (a & ~mask) | (inc & mask);
      default:
        next_addr = inc;
    endcase
  endfunction

  logic [1:0]            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;

  logic aw_fire, w_fire, b_fire;
  assign aw_fire = s_axi_awvalid & awready_q;
  assign w_fire  = s_axi_wvalid & wready_q;
  assign b_fire  = bvalid_q & s_axi_bready;

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    case (w_state_q)
      W_IDLE: if (aw_fire) begin
        aw_id_d    = s_axi_awid;
        aw_addr_d  = s_axi_awaddr;
        aw_len_d   = s_axi_awlen;
        aw_burst_d = s_axi_awburst;
        w_cnt_d    = s_axi_awlen;
        w_state_d  = W_DATA;
      end
      W_DATA: if (w_fire) begin
        aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_burst_q);
        w_cnt_d   = w_cnt_q - 8'd1;
        if (w_cnt_q == 8'd0) w_state_d = W_RESP;
      end
      W_RESP: if (b_fire) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
    end
  end

  // Storage is never reset; only strobed lanes are updated.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) begin
          mem_q[aw_addr_q[ADDR_WIDTH-1:OFF]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  logic [0:0]            r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic ar_fire, r_fire;
  assign ar_fire = s_axi_arvalid & arready_q;
  assign r_fire  = rvalid_q & s_axi_rready;

  // Data is fetched one cycle ahead and held, so stalls keep it stable.
  always_comb begin
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    case (r_state_q)
      R_IDLE: if (ar_fire) begin
        rid_d      = s_axi_arid;
        rdata_d    = mem_q[s_axi_araddr[ADDR_WIDTH-1:OFF]];
        ar_addr_d  = next_addr(s_axi_araddr, s_axi_arlen, s_axi_arburst);
        ar_len_d   = s_axi_arlen;
        ar_burst_d = s_axi_arburst;
        r_cnt_d    = s_axi_arlen;
        rlast_d    = (s_axi_arlen == 8'd0);
        rvalid_d   = 1'b1;
        r_state_d  = R_DATA;
      end
      R_DATA: if (r_fire) begin
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          rdata_d   = mem_q[ar_addr_q[ADDR_WIDTH-1:OFF]];
          ar_addr_d = next_addr(ar_addr_q, ar_len_q, ar_burst_q);
          r_cnt_d   = r_cnt_q - 8'd1;
          rlast_d   = (r_cnt_q == 8'd1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
    end
  end

  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bid     = aw_id_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder: bursts, strobes, stalls, reset.
// Expected data is hand-computed per step.
module tb_axi_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  awid, arid, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int errors = 0;
  int checks = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [16];

  always #5 clk = ~clk;

  axi_ram_responder dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr),
    .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr),
    .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_burst(input logic [7:0] id,
                             input logic [15:0] addr,
                             input logic [7:0] len,
                             input logic [1:0] burst,
                             input int nbeats,
                             input string tag);
    int n;
    awid = id; awaddr = addr; awlen = len;
    awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_aw_wait"}, 64'(n < 50), 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i];
      wlast = (i == int'(len)); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_w_wait"}, 64'(n < 50), 1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (nbeats == int'(len) + 1) begin
      bready = 1'b1;
      n = 0;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_b_wait"}, 64'(n < 50), 1);
      chk({tag, "_bid"}, 64'(bid), 64'(id));
      chk({tag, "_bresp"}, 64'(bresp), 0);
      @(negedge clk);
      bready = 1'b0;
      chk({tag, "_bvalid_clr"}, 64'(bvalid), 0);
      chk({tag, "_awready_back"}, 64'(awready), 1);
    end
  endtask

  task automatic read_burst(input logic [7:0] id,
                            input logic [15:0] addr,
                            input logic [7:0] len,
                            input logic [1:0] burst,
                            input bit toggle,
                            input string tag);
    int n, beats, cyc;
    bit stalled;
    logic [31:0] held_d;
    logic        held_l;
    arid = id; araddr = addr; arlen = len;
    arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_ar_wait"}, 64'(n < 50), 1);
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, "_first_rvalid"}, 64'(rvalid), 1);
    beats = 0; cyc = 0; stalled = 0;
    held_d = '0; held_l = 1'b0;
    while (beats <= int'(len) && cyc < 200) begin
      rready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (rvalid) begin
        chk({tag, "_arready_busy"}, 64'(arready), 0);
        if (stalled) begin
          chk({tag, "_stall_data"}, 64'(rdata), 64'(held_d));
          chk({tag, "_stall_last"}, 64'(rlast), 64'(held_l));
        end
        if (rready) begin
          rbuf[beats] = rdata;
          chk($sformatf("%s_rlast%0d", tag, beats),
              64'(rlast), 64'(beats == int'(len)));
          chk({tag, "_rid"}, 64'(rid), 64'(id));
          chk({tag, "_rresp"}, 64'(rresp), 0);
          beats++;
          stalled = 0;
        end else begin
          held_d = rdata; held_l = rlast; stalled = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    chk({tag, "_r_wait"}, 64'(cyc < 200), 1);
    chk({tag, "_rvalid_clr"}, 64'(rvalid), 0);
    chk({tag, "_arready_back"}, 64'(arready), 1);
  endtask

  task automatic chk_rbuf(input string tag, input int i,
                          input logic [31:0] exp);
    chk($sformatf("%s_data%0d", tag, i), 64'(rbuf[i]), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 0;
    rready = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_awready", 64'(awready), 0);
    chk("rst_wready", 64'(wready), 0);
    chk("rst_bvalid", 64'(bvalid), 0);
    chk("rst_arready", 64'(arready), 0);
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_rlast", 64'(rlast), 0);
    chk("rst_rdata", 64'(rdata), 0);
    rst_n = 1'b1;
    chk("rel_awready_pre", 64'(awready), 0);
    @(negedge clk);
    chk("rel_awready", 64'(awready), 1);
    chk("rel_arready", 64'(arready), 1);

    // 1: single beat
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    write_burst(8'd3, 16'h0010, 8'd0, 2'b01, 1, "t1w");
    read_burst(8'd5, 16'h0010, 8'd0, 2'b01, 0, "t1r");
    chk_rbuf("t1", 0, 32'hDEADBEEF);

    // 2: INCR with partial strobe over 0xFFFFFFFF
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hFFFFFFFF; sbuf[i] = 4'hF;
    end
    write_burst(8'd1, 16'h0100, 8'd3, 2'b01, 4, "t2pre");
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    sbuf[1] = 4'h3;
    write_burst(8'd2, 16'h0100, 8'd3, 2'b01, 4, "t2w");
    read_burst(8'd7, 16'h0100, 8'd3, 2'b11, 0, "t2r");
    chk_rbuf("t2", 0, 32'd1);
    chk_rbuf("t2", 1, 32'hFFFF0002);
    chk_rbuf("t2", 2, 32'd3);
    chk_rbuf("t2", 3, 32'd4);

    // 3: WRAP write from 0x108
    wbuf[0] = 32'hAAAA0001; wbuf[1] = 32'hBBBB0002;
    wbuf[2] = 32'hCCCC0003; wbuf[3] = 32'hDDDD0004;
    for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
    write_burst(8'h44, 16'h0108, 8'd3, 2'b10, 4, "t3w");
    read_burst(8'h45, 16'h0100, 8'd3, 2'b01, 0, "t3r");
    chk_rbuf("t3", 0, 32'hCCCC0003);
    chk_rbuf("t3", 1, 32'hDDDD0004);
    chk_rbuf("t3", 2, 32'hAAAA0001);
    chk_rbuf("t3", 3, 32'hBBBB0002);
    read_burst(8'h46, 16'h0108, 8'd3, 2'b10, 0, "t3wr");
    chk_rbuf("t3wr", 0, 32'hAAAA0001);
    chk_rbuf("t3wr", 1, 32'hBBBB0002);
    chk_rbuf("t3wr", 2, 32'hCCCC0003);
    chk_rbuf("t3wr", 3, 32'hDDDD0004);

    // 4: FIXED keeps the last beat
    write_burst(8'h09, 16'h0020, 8'd3, 2'b00, 4, "t4w");
    read_burst(8'h0A, 16'h0020, 8'd1, 2'b00, 0, "t4r");
    chk_rbuf("t4", 0, 32'hDDDD0004);
    chk_rbuf("t4", 1, 32'hDDDD0004);

    // 5: len=7 read with rready toggling
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 32'h50 + 32'(i); sbuf[i] = 4'hF;
    end
    write_burst(8'h0B, 16'h0300, 8'd7, 2'b01, 8, "t5w");
    read_burst(8'h0C, 16'h0300, 8'd7, 2'b01, 1, "t5r");
    for (int i = 0; i < 8; i++) chk_rbuf("t5", i, 32'h50 + 32'(i));

    // 6: reset in the middle of a write burst
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF;
    end
    write_burst(8'h0D, 16'h0200, 8'd3, 2'b01, 4, "t6pre");
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    write_burst(8'h0E, 16'h0200, 8'd3, 2'b01, 2, "t6w");
    chk("t6_wready_pre", 64'(wready), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_wready_rst", 64'(wready), 0);
    chk("t6_bvalid_rst", 64'(bvalid), 0);
    chk("t6_awready_rst", 64'(awready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_awready_rel", 64'(awready), 0);
    @(negedge clk);
    chk("t6_awready_edge", 64'(awready), 1);
    chk("t6_wready_idle", 64'(wready), 0);
    read_burst(8'h0F, 16'h0200, 8'd3, 2'b01, 0, "t6r");
    chk_rbuf("t6", 0, 32'hA0);
    chk_rbuf("t6", 1, 32'hA1);
    chk_rbuf("t6", 2, 32'hC2);
    chk_rbuf("t6", 3, 32'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
